// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtract cell reused per bit.
// Ports: clk, rst, start, a, b -> busy, done, d, borrow_out.

module halfsubtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);
  assign diff   = x ^ y;
  assign borrow = ~x & y;
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] rreg;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic             d1;
  logic             borrow1;
  logic             dbit;
  logic             borrow2;
  logic             next_brw;
  logic [WIDTH-1:0] dvec;
  logic [WIDTH-1:0] nxt_r;
  logic             last;

  halfsubtractor hs1 (
    .x     (areg[0]),
    .y     (breg[0]),
    .diff  (d1),
    .borrow(borrow1)
  );

  halfsubtractor hs2 (
    .x     (d1),
    .y     (brw),
    .diff  (dbit),
    .borrow(borrow2)
  );

  assign next_brw = borrow1 | borrow2;
  assign last     = (cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB; after WIDTH steps bit i is at i.
  always_comb begin
    dvec            = '0;
    dvec[WIDTH-1]   = dbit;
    nxt_r           = (rreg >> 1) | dvec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      areg       <= '0;
      breg       <= '0;
      rreg       <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      d          <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            rreg  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          rreg <= nxt_r;
          areg <= areg >> 1;
          breg <= breg >> 1;
          brw  <= next_brw;
          cnt  <= cnt + CW'(1);
          if (last) begin
            d          <= nxt_r;
            borrow_out <= next_brw;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH 8, 4 and 1.
// Stimulus and sampling on the falling clock edge.

module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic       start8, busy8, done8, bo8;
  logic [7:0] a8, b8, d8;
  logic       start4, busy4, done4, bo4;
  logic [3:0] a4, b4, d4;
  logic       start1, busy1, done1, bo1;
  logic [0:0] a1, b1, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .borrow_out(bo4)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .d(d1), .borrow_out(bo1)
  );

  // Issue one WIDTH=8 op; report done latency (-1 on timeout) and busy count.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output int bcnt);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1; bcnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (done8) begin
        lat = j;
        break;
      end
      if (busy8) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0;
    start4 = 0; a4 = 0; b4 = 0;
    start1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, d8, bo8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b d=%h bo=%b, want all 0",
               busy8, done8, d8, bo8);
    end
    checks++;
    if ({busy4, done4, d4, bo4, busy1, done1, d1, bo1} !== 11'd0) begin
      errors++;
      $display("FAIL reset4_1: got d4=%h bo4=%b d1=%b bo1=%b, want 0",
               d4, bo4, d1, bo1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run8(8'h5A, 8'h3C, lat, bcnt);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    checks++;
    if (bcnt !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt);
    end
    checks++;
    if (d8 !== 8'h1E || bo8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got d=%h bo=%b busy=%b, want 1e 0 0",
               d8, bo8, busy8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || d8 !== 8'h1E) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b d=%h, want 0 1e",
               done8, d8);
    end
  endtask

  task automatic test_borrow();
    int lat, bcnt;
    run8(8'h00, 8'h01, lat, bcnt);
    checks++;
    if (lat !== 8 || d8 !== 8'hFF || bo8 !== 1'b1) begin
      errors++;
      $display("FAIL borrow_wrap: got lat=%0d d=%h bo=%b, want 8 ff 1",
               lat, d8, bo8);
    end
    @(negedge clk);
    run8(8'h80, 8'h80, lat, bcnt);
    checks++;
    if (lat !== 8 || d8 !== 8'h00 || bo8 !== 1'b0) begin
      errors++;
      $display("FAIL borrow_equal: got lat=%0d d=%h bo=%b, want 8 00 0",
               lat, d8, bo8);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int ndone;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int j = 0; j < 25; j++) begin
      if (done8) begin
        ndone++;
        checks++;
        if (d8 !== 8'h0F || bo8 !== 1'b0) begin
          errors++;
          $display("FAIL busy_start_result: got d=%h bo=%b, want 0f 0",
                   d8, bo8);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_single: got %0d dones busy=%b, want 1 0",
               ndone, busy8);
    end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bcnt;
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, d8, bo8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got busy=%b done=%b d=%h bo=%b, want 0",
               busy8, done8, d8, bo8);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      if (done8 || busy8) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0 || d8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d active cycles d=%h, want 0 00",
               ndone, d8);
    end
    run8(8'h33, 8'h11, lat, bcnt);
    checks++;
    if (lat !== 8 || d8 !== 8'h22 || bo8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh: got lat=%0d d=%h bo=%b, want 8 22 0",
               lat, d8, bo8);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [3] = '{8'h12, 8'hFF, 8'h7F};
    logic [7:0] pb [3] = '{8'h34, 8'h01, 8'h80};
    logic [7:0] ed [3] = '{8'hDE, 8'hFE, 8'hFF};
    logic       eb [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] held;
    logic       prev_busy;
    int acc, ndone, last_rise;
    held = 8'h22;
    @(negedge clk);
    a8 = pa[0]; b8 = pb[0]; start8 = 1'b1;
    prev_busy = 1'b0; acc = 0; ndone = 0; last_rise = -1;
    for (int j = 0; j < 60 && ndone < 3; j++) begin
      @(negedge clk);
      if (busy8 && !prev_busy) begin
        if (last_rise >= 0) begin
          checks++;
          if (j - last_rise !== 10) begin
            errors++;
            $display("FAIL b2b_interval: got %0d, want 10", j - last_rise);
          end
        end
        last_rise = j;
        acc++;
        if (acc < 3) begin
          a8 = pa[acc]; b8 = pb[acc];
        end else begin
          start8 = 1'b0;
          a8 = 8'h00; b8 = 8'hAA;
        end
      end
      prev_busy = busy8;
      if (done8) begin
        checks++;
        if (d8 !== ed[ndone] || bo8 !== eb[ndone]) begin
          errors++;
          $display("FAIL b2b_result%0d: got d=%h bo=%b, want %h %b",
                   ndone, d8, bo8, ed[ndone], eb[ndone]);
        end
        held = ed[ndone];
        ndone++;
      end else if (d8 !== held) begin
        checks++;
        errors++;
        $display("FAIL b2b_hold: got d=%h, want %h", d8, held);
      end
    end
    start8 = 1'b0;
    checks++;
    if (ndone !== 3 || acc !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts %0d dones, want 3 3",
               acc, ndone);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [3:0] ed;
    logic       eb;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        a4 = 4'(i); b4 = 4'(k); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'(~i); b4 = 4'(i + k);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
          if (done4) begin
            lat = j;
            break;
          end
          @(negedge clk);
        end
        ed = 4'((i - k) & 15);
        eb = (i < k);
        checks++;
        if (lat !== 4 || d4 !== ed || bo4 !== eb) begin
          errors++;
          $display("FAIL w4_%0d_%0d: got lat=%0d d=%h bo=%b, want 4 %h %b",
                   i, k, lat, d4, bo4, ed, eb);
        end
      end
    end
  endtask

  task automatic test_width1();
    int lat;
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    lat = -1;
    for (int j = 0; j < 10; j++) begin
      if (done1) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 1 || d1 !== 1'b1 || bo1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_smoke: got lat=%0d d=%b bo=%b, want 1 1 1",
               lat, d1, bo1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive4();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
